// File: rtl/barrel_shift_arbiter.sv
// Two-requester round-robin front end sharing one 8-bit rotate datapath.
// One operation in flight at a time: IDLE grants, CALC registers the result, HOLD waits for the consumer.

module barrel_shift_prepost #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic [WIDTH-1:0] x,
    input  logic [SHW-1:0]   shift,
    input  logic             lr,
    output logic [WIDTH-1:0] y
);
    // Right rotation reuses the left-rotate stages by bit-reversing before and after.
    logic [WIDTH-1:0]          x_rev;
    logic [WIDTH-1:0]          y_rev;
    logic [SHW:0][WIDTH-1:0]   stg;

    genvar b, s;
    generate
        for (b = 0; b < WIDTH; b++) begin : g_rev
            assign x_rev[b] = x[WIDTH-1-b];
            assign y_rev[b] = stg[SHW][WIDTH-1-b];
        end

        for (s = 0; s < SHW; s++) begin : g_stage
            localparam int K = 1 << s;
            assign stg[s+1] = shift[s] ? {stg[s][WIDTH-1-K:0], stg[s][WIDTH-1:WIDTH-K]}
                                       : stg[s];
        end
    endgenerate

    assign stg[0] = lr ? x_rev : x;
    assign y      = lr ? y_rev : stg[SHW];
endmodule

module barrel_shift_arbiter #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_x,
    input  logic [WIDTH-1:0] req1_x,
    input  logic [SHW-1:0]   req0_shift,
    input  logic [SHW-1:0]   req1_shift,
    input  logic             req0_lr,
    input  logic             req1_lr,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_id,
    output logic             busy,
    output logic [15:0]      op_count
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] x;
        logic [SHW-1:0]   shift;
        logic             lr;
    } op_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic             grant_id_q, grant_id_d;
    op_t              op_q, op_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
    logic             rsp_id_q, rsp_id_d;
    logic [15:0]      op_count_q, op_count_d;

    logic             winner;
    logic             grant;
    op_t              req_op [2];
    logic [WIDTH-1:0] shf_y;

    assign req_op[0] = '{x: req0_x, shift: req0_shift, lr: req0_lr};
    assign req_op[1] = '{x: req1_x, shift: req1_shift, lr: req1_lr};

    // With both pending, the side that did not win last time goes next.
    always_comb begin
        winner = req_valid[1];
        if (&req_valid) winner = ~last_q;
        grant     = (state_q == S_IDLE) && (|req_valid);
        req_ready = '0;
        if (grant) req_ready[winner] = 1'b1;
    end

    barrel_shift_prepost #(.WIDTH(WIDTH), .SHW(SHW)) u_shf (
        .x     (op_q.x),
        .shift (op_q.shift),
        .lr    (op_q.lr),
        .y     (shf_y)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant_id_d  = grant_id_q;
        op_d        = op_q;
        rsp_valid_d = rsp_valid_q;
        rsp_y_d     = rsp_y_q;
        rsp_id_d    = rsp_id_q;
        op_count_d  = op_count_q;
        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    op_d       = req_op[winner];
                    grant_id_d = winner;
                    last_d     = winner;
                    state_d    = S_CALC;
                end
            end
            S_CALC: begin
                rsp_y_d     = shf_y;
                rsp_id_d    = grant_id_q;
                rsp_valid_d = 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + 16'd1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            grant_id_q  <= 1'b0;
            op_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= '0;
            rsp_id_q    <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            grant_id_q  <= grant_id_d;
            op_q        <= op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            rsp_id_q    <= rsp_id_d;
            op_count_q  <= op_count_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != S_IDLE);
    assign op_count  = op_count_q;
endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Bench for barrel_shift_arbiter: transaction-level model checked every cycle,
// directed scenarios pinned with literal values, then randomized traffic.

module tb_barrel_shift_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid, req_ready;
    logic [7:0] req0_x, req1_x;
    logic [2:0] req0_shift, req1_shift;
    logic       req0_lr, req1_lr;
    logic       rsp_valid, rsp_ready, rsp_id, busy;
    logic [7:0] rsp_y;
    logic [15:0] op_count;

    int total = 0;
    int bad   = 0;

    barrel_shift_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_x(req0_x), .req1_x(req1_x),
        .req0_shift(req0_shift), .req1_shift(req1_shift),
        .req0_lr(req0_lr), .req1_lr(req1_lr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_id(rsp_id),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Model: an operation is either absent, being computed, or waiting on the consumer.
    int          m_stage;
    bit          m_last;
    logic [7:0]  m_y, m_py;
    bit          m_id, m_pid;
    logic [15:0] m_cnt;
    bit   [1:0]  g_grant;

    function automatic logic [7:0] rot(input logic [7:0] x, input int s, input bit right);
        int v;
        int r;
        v = int'(x);
        if (s == 0) return x;
        if (right) r = (v >> s) | (v << (8 - s));
        else       r = (v << s) | (v >> (8 - s));
        return 8'(r & 255);
    endfunction

    function automatic bit pick();
        if (req_valid == 2'b11) return ~m_last;
        return req_valid[1];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stage = 0; m_last = 1'b1; m_cnt = 16'd0;
        m_y = 8'h00; m_id = 1'b0; g_grant = 2'b00;
    endtask

    task automatic check_and_advance();
        logic [1:0] exp_rdy;
        bit w;
        exp_rdy = 2'b00;
        w = pick();
        if (m_stage == 0 && req_valid != 2'b00) exp_rdy[w] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_stage == 2));
        chk("busy",      32'(busy),      32'(m_stage != 0));
        chk("op_count",  32'(op_count),  32'(m_cnt));
        if (m_stage == 2) begin
            chk("rsp_y",  32'(rsp_y),  32'(m_y));
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
        end
        g_grant = exp_rdy;
        case (m_stage)
            0: if (req_valid != 2'b00) begin
                m_py    = w ? rot(req1_x, int'(req1_shift), req1_lr)
                            : rot(req0_x, int'(req0_shift), req0_lr);
                m_pid   = w;
                m_last  = w;
                m_stage = 1;
            end
            1: begin m_y = m_py; m_id = m_pid; m_stage = 2; end
            default: if (rsp_ready) begin m_cnt = m_cnt + 16'd1; m_stage = 0; end
        endcase
    endtask

    task automatic cycle();
        @(negedge clk);
        check_and_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [7:0] x, input logic [2:0] s, input logic lr);
        if (i == 0) begin req0_x = x; req0_shift = s; req0_lr = lr; end
        else        begin req1_x = x; req1_shift = s; req1_lr = lr; end
    endtask

    task automatic run_one(input logic [7:0] x, input logic [2:0] s, input logic lr,
                           input logic [7:0] exp, input string name);
        set_req(0, x, s, lr);
        req_valid = 2'b01; rsp_ready = 1'b1;
        cycle();
        req_valid = 2'b00;
        cycle();
        chk(name, 32'(rsp_y), 32'(exp));
        cycle();
    endtask

    initial begin
        int k;
        int idle_n;
        logic [7:0] held_y;
        rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
        set_req(0, 8'h00, 3'd0, 1'b0);
        set_req(1, 8'h00, 3'd0, 1'b0);
        #1;
        model_reset();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_y",     32'(rsp_y),     32'h00);
        chk("rst_rsp_id",    32'(rsp_id),    32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_op_count",  32'(op_count),  32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single request from requester 0.
        set_req(0, 8'hB3, 3'd1, 1'b0);
        req_valid = 2'b01;
        #1 chk("t1_ready", 32'(req_ready), 32'b01);
        cycle();
        chk("t1_ready_drop", 32'(req_ready), 32'b00);
        req_valid = 2'b00;
        cycle();
        chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t1_rsp_y",     32'(rsp_y),     32'h67);
        chk("t1_rsp_id",    32'(rsp_id),    32'd0);
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;
        chk("t1_op_count", 32'(op_count), 32'd1);

        // Both requesters continuously valid: grants alternate.
        do_reset();
        set_req(0, 8'hB3, 3'd2, 1'b0);
        set_req(1, 8'hB3, 3'd2, 1'b1);
        req_valid = 2'b11; rsp_ready = 1'b1;
        k = 0; idle_n = 0;
        for (int c = 0; c < 12; c++) begin
            cycle();
            if (!busy) idle_n++;
            if (rsp_valid) begin
                chk("rr_id", 32'(rsp_id), 32'(k % 2));
                chk("rr_y",  32'(rsp_y),  (k % 2) ? 32'hEC : 32'hCE);
                k++;
            end
        end
        chk("rr_results", 32'(k), 32'd4);
        chk("rr_idle_cycles", 32'(idle_n), 32'd4);
        req_valid = 2'b00;
        repeat (3) cycle();

        // Backpressure while requester 1 waits.
        rsp_ready = 1'b0;
        set_req(0, 8'h3C, 3'd3, 1'b1);
        req_valid = 2'b01;
        cycle();
        req_valid = 2'b10;
        set_req(1, 8'h5A, 3'd4, 1'b0);
        cycle();
        held_y = rsp_y;
        chk("bp_y_first", 32'(held_y), 32'h87);
        for (int c = 0; c < 10; c++) begin
            cycle();
            chk("bp_y_stable",  32'(rsp_y),     32'(held_y));
            chk("bp_id_stable", 32'(rsp_id),    32'd0);
            chk("bp_ready_low", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;
        chk("bp_grant1", 32'(req_ready), 32'b10);
        cycle();
        req_valid = 2'b00;
        cycle();
        chk("bp_rsp1_y", 32'(rsp_y), 32'hA5);
        rsp_ready = 1'b1;
        cycle();

        // Boundary operands.
        run_one(8'h00, 3'd3, 1'b0, 8'h00, "bnd_zero");
        run_one(8'hFF, 3'd5, 1'b1, 8'hFF, "bnd_ones");
        run_one(8'hB3, 3'd0, 1'b0, 8'hB3, "bnd_s0_left");
        run_one(8'hB3, 3'd0, 1'b1, 8'hB3, "bnd_s0_right");

        // Reset pulse while holding a response.
        rsp_ready = 1'b0;
        set_req(0, 8'h81, 3'd1, 1'b0);
        req_valid = 2'b01;
        cycle();
        req_valid = 2'b00;
        cycle();
        chk("mid_hold", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_busy",      32'(busy),      32'd0);
        chk("mid_op_count",  32'(op_count),  32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        set_req(1, 8'h11, 3'd1, 1'b1);
        req_valid = 2'b11;
        #1 chk("mid_first_req0", 32'(req_ready), 32'b01);
        rsp_ready = 1'b1;
        cycle();
        req_valid = 2'b00;
        repeat (3) cycle();

        // Counter wrap.
        force dut.op_count_q = 16'hFFFF;
        #1;
        release dut.op_count_q;
        m_cnt = 16'hFFFF;
        run_one(8'h12, 3'd4, 1'b0, 8'h21, "wrap_y");
        chk("wrap_count", 32'(op_count), 32'h0000);

        // Randomized traffic.
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && !g_grant[i]) begin
                    if ($urandom_range(9) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(2) == 0) begin
                    req_valid[i] = 1'b1;
                    set_req(i, 8'($urandom), 3'($urandom), 1'($urandom));
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(2) != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/barrel_shift_arbiter.md
# barrel_shift_arbiter

Sequencer and round-robin arbiter that shares one 8-bit `barrel_shift_prepost` datapath between two requesters. Each requester presents an operand, shift amount and direction with a valid/ready handshake. The block grants one request at a time, registers the operands into the shifter, and registers the result. It then holds the result on a single tagged response channel until the consumer accepts it. The block sits between the requesting engines and the shared shifter.

## Interface
Parameters:
- `WIDTH`, 8: operand/result width; fixed by the shared shifter.
- `SHW`, 3: shift-amount width; equals log2(`WIDTH`).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  2  bit i: requester i has an operation pending.
- `req_ready`  out  2  bit i: requester i's operation is accepted this cycle.
- `req0_x`, `req1_x`  in  `WIDTH`  operand per requester.
- `req0_shift`, `req1_shift`  in  `SHW`  shift amount per requester.
- `req0_lr`, `req1_lr`  in  1  direction per requester: 0 = rotate left, 1 = rotate right.
- `rsp_valid`  out  1  result held on `rsp_y`.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_y`  out  `WIDTH`  shifter result.
- `rsp_id`  out  1  index of the requester that owns the result.
- `busy`  out  1  high in any state other than IDLE.
- `op_count`  out  16  count of completed response handshakes; wraps.

## Operation
- Contains one `barrel_shift_prepost` instance fed from internal registers `op_x`, `op_shift`, `op_lr`. Its `y` is combinational.
- FSM states:
  - IDLE: waiting for a request. On any `req_valid` it grants, captures operands, latches `grant_id` and goes to CALC.
  - CALC: captures shifter `y` into `rsp_y`, copies `grant_id` to `rsp_id`, sets `rsp_valid` and goes to HOLD.
  - HOLD: keeps `rsp_valid` high. On `rsp_ready` it clears `rsp_valid`, increments `op_count` and returns to IDLE.
- Arbitration: round-robin with a 1-bit `last` pointer that resets to 1, so requester 0 wins first.
  - Only one requester valid: it wins.
  - Both valid: the requester other than `last` wins.
  - `last` is updated to the winner at grant.
- `req_ready[i]` = (state == IDLE) & `req_valid[i]` & (winner == i). The signal is combinational and at most one bit is high.
- Requesters must hold their operands stable while `req_valid` is high and `req_ready` is low. The block captures operands only on the handshake edge.
- No new grant is issued in CALC or HOLD. Pending requests wait, and fairness is preserved through `last`.
- `op_count` is 16 bits and wraps from 0xFFFF to 0x0000.
- Arithmetic: rotation only, no fill bits. Shift 0 returns `x` unchanged.

## Timing
- Reset values (asserted asynchronously): state IDLE; `req_ready` 0 (no valid input); `rsp_valid` 0; `rsp_y` 0x00; `rsp_id` 0; `busy` 0; `op_count` 0; `last` 1; operand registers 0.
- Latency: request accepted at edge k; `rsp_valid` high after edge k+1, in the HOLD state.
- Response hold:
  - `rsp_valid`, `rsp_y` and `rsp_id` stay stable until the edge where `rsp_valid` & `rsp_ready` are both high.
  - `rsp_valid` falls after that edge.
- Throughput: with `rsp_ready` tied high, one operation per 3 cycles (IDLE, CALC, HOLD).
- `rsp_ready` asserted while `rsp_valid` is low: ignored.
- Requester drops `req_valid` before it is granted: no operation is recorded.
- Reset asserted mid-operation (CALC or HOLD):
  - The in-flight operation is discarded and `rsp_valid` drops immediately.
  - After reset is released, requester 0 is served first.

## Test plan
- Reset, then requester 0 with `x` = 0xB3, shift 1, lr 0 → `req_ready[0]` pulses for one cycle; two edges later `rsp_valid` = 1, `rsp_y` = 0x67, `rsp_id` = 0; `op_count` = 1 after the handshake.
- Both requesters valid continuously; req0 = {0xB3, 2, 0}, req1 = {0xB3, 2, 1}, `rsp_ready` = 1 → grants alternate 0, 1, 0, 1; results 0xCE, 0xEC, 0xCE, 0xEC; every third cycle `busy` is low.
- Backpressure: hold `rsp_ready` = 0 for 10 cycles while req1 stays valid → `rsp_y` and `rsp_id` stay stable and `req_ready` stays 0; after `rsp_ready` rises, req1 is granted in the following IDLE cycle.
- Boundary values: `x` = 0x00 with shift 3 lr 0 → 0x00; `x` = 0xFF with shift 5 lr 1 → 0xFF; `x` = 0xB3 with shift 0 in both directions → 0xB3.
- Pulse `rst_n` low during HOLD → `rsp_valid`, `busy` and `op_count` go to 0 immediately; the next simultaneous request is granted to requester 0.
- Force `op_count` to 0xFFFF, then complete one operation → `op_count` = 0x0000.
